// File: rtl/grover_measure.sv
// Measurement stage for the Grover core: squares the captured amplitude vector,
// then draws an LFSR-scaled threshold against the cumulative probability.

module grover_measure_sq #(
  parameter int FP_BIT = 8
) (
  input  logic [FP_BIT-1:0]   amp,
  output logic [2*FP_BIT-2:0] sq
);
  localparam int SQ_W = 2*FP_BIT-1;

  logic [FP_BIT-1:0] mag;
  logic [SQ_W-1:0]   mag_x;

  // Magnitude of the most negative code still fits FP_BIT unsigned bits
  assign mag   = amp[FP_BIT-1] ? ('0 - amp) : amp;
  assign mag_x = {{(SQ_W-FP_BIT){1'b0}}, mag};
  assign sq    = mag_x * mag_x;
endmodule

module grover_measure #(
  parameter int          NUM_BIT = 3,
  parameter int          FP_BIT  = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [(2**NUM_BIT)*FP_BIT-1:0]  amp_in,
  input  logic                            seed_load,
  input  logic [15:0]                     seed,
  output logic                            busy,
  output logic                            result_valid,
  output logic [NUM_BIT-1:0]              result_idx,
  output logic [2*FP_BIT-2:0]             result_prob,
  output logic [NUM_BIT-1:0]              argmax_idx,
  output logic                            zero_err
);
  localparam int NUM_SAMPLE = 2**NUM_BIT;
  localparam int SQ_W       = 2*FP_BIT-1;
  localparam int TOT_W      = SQ_W+NUM_BIT;
  localparam logic [NUM_BIT-1:0] K_LAST = '1;
  localparam logic [NUM_BIT-1:0] K_ONE  = {{(NUM_BIT-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, SUM, SCALE, SCAN, DONE} state_t;
  state_t state, state_n;

  logic [NUM_SAMPLE-1:0][FP_BIT-1:0] amp_r;
  logic [NUM_SAMPLE-1:0][SQ_W-1:0]   sq_all;
  logic [15:0]        lfsr, lfsr_nx, th_src;
  logic [NUM_BIT-1:0] k, max_idx;
  logic [SQ_W-1:0]    sq_sel, max_sq;
  logic [TOT_W-1:0]   sq_ext, total, th, th_nx, cum, cum_nx;
  logic               hit;

  for (genvar g = 0; g < NUM_SAMPLE; g++) begin : g_sq
    grover_measure_sq #(.FP_BIT(FP_BIT)) u_sq (.amp(amp_r[g]), .sq(sq_all[g]));
  end

  assign sq_sel  = sq_all[k];
  assign sq_ext  = {{NUM_BIT{1'b0}}, sq_sel};
  assign cum_nx  = cum + sq_ext;
  assign hit     = (cum_nx > th) || (k == K_LAST);
  assign lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  // Fraction th_src/2^16 of total; strictly below total whenever total > 0
  assign th_nx   = TOT_W'(({{TOT_W{1'b0}}, th_src} * {16'b0, total}) >> 16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SUM;
      SUM:     if (k == K_LAST) state_n = SCALE;
      SCALE:   state_n = (total == '0) ? DONE : SCAN;
      SCAN:    if (hit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr         <= SEED;
      th_src       <= '0;
      amp_r        <= '0;
      k            <= '0;
      total        <= '0;
      max_sq       <= '0;
      max_idx      <= '0;
      th           <= '0;
      cum          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      result_prob  <= '0;
      argmax_idx   <= '0;
      zero_err     <= 1'b0;
    end else begin
      busy         <= (state_n != IDLE);
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            amp_r   <= amp_in;
            th_src  <= lfsr;
            lfsr    <= lfsr_nx;
            k       <= '0;
            total   <= '0;
            max_sq  <= '0;
            max_idx <= '0;
          end else if (seed_load) begin
            lfsr <= (seed == 16'h0000) ? SEED : seed;
          end
        end
        SUM: begin
          total <= total + sq_ext;
          if (sq_sel > max_sq) begin
            max_sq  <= sq_sel;
            max_idx <= k;
          end
          k <= k + K_ONE;
        end
        SCALE: begin
          th  <= th_nx;
          cum <= '0;
          k   <= '0;
          if (total == '0) begin
            zero_err     <= 1'b1;
            result_idx   <= '0;
            result_prob  <= '0;
            argmax_idx   <= max_idx;
            result_valid <= 1'b1;
          end
        end
        SCAN: begin
          cum <= cum_nx;
          if (hit) begin
            zero_err     <= 1'b0;
            result_idx   <= k;
            result_prob  <= sq_sel;
            argmax_idx   <= max_idx;
            result_valid <= 1'b1;
          end else begin
            k <= k + K_ONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
